// File: rtl/read_control_sync.sv
// ---------------------------------------------------------------------------
// read_control_sync
//
// Read-side controller for an asynchronous FIFO. Runs entirely in the read
// clock domain. It owns the read binary and Gray pointers, brings the write
// Gray pointer across the clock boundary through a SyncStages-deep flop
// chain, and produces registered empty / almost-empty / fill-level status.
// It also produces a read-data-valid strobe that lines up with a registered
// RAM read port.
//
// Optional feature macro: RD_UNDERFLOW_FLAG_EN
//   defined   : o_underflow is a sticky flag, set by a read request while
//               empty and cleared only by rst_rd.
//   undefined : o_underflow is tied to 0 and no flop exists for it.
//
// Parameters
//   PtrWidth       RAM address width; depth = 2**PtrWidth, pointers are
//                  PtrWidth+1 bits (the MSB tells the two laps apart)
//   SyncStages     flops in the write-pointer synchroniser (>= 2)
//   AlmostEmptyThr o_almost_empty is asserted while level <= this value
//
// Ports
//   clk_rd          in   read-domain clock, rising edge
//   rst_rd          in   synchronous active-high reset
//   i_rd_en         in   consumer read request (ignored while empty)
//   i_wr_gray_ptr   in   write Gray pointer, asynchronous to clk_rd
//   o_bin_ptr       out  read binary pointer
//   o_gray_ptr      out  read Gray pointer, to the write domain
//   o_addr          out  RAM read address (low PtrWidth bits of o_bin_ptr)
//   o_rd_valid      out  RAM data valid, one cycle after an accepted read
//   o_empty         out  FIFO empty
//   o_almost_empty  out  level <= AlmostEmptyThr
//   o_level         out  entries available, 0 .. 2**PtrWidth
//   o_underflow     out  sticky underflow error (see macro above)
// ---------------------------------------------------------------------------
module read_control_sync #(
  parameter int PtrWidth       = 2,
  parameter int SyncStages     = 2,
  parameter int AlmostEmptyThr = 1
) (
  input  logic                clk_rd,
  input  logic                rst_rd,
  input  logic                i_rd_en,
  input  logic [PtrWidth:0]   i_wr_gray_ptr,
  output logic [PtrWidth:0]   o_bin_ptr,
  output logic [PtrWidth:0]   o_gray_ptr,
  output logic [PtrWidth-1:0] o_addr,
  output logic                o_rd_valid,
  output logic                o_empty,
  output logic                o_almost_empty,
  output logic [PtrWidth:0]   o_level,
  output logic                o_underflow
);

  localparam int PW = PtrWidth + 1;
  localparam logic [PtrWidth:0] THR = PW'(AlmostEmptyThr);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PtrWidth:0] sync_q [SyncStages];
  logic [PtrWidth:0] sync_d [SyncStages];

  logic [PtrWidth:0] bin_q,   bin_d;
  logic [PtrWidth:0] gray_q,  gray_d;
  logic [PtrWidth:0] level_q, level_d;
  logic              empty_q, empty_d;
  logic              almost_empty_q, almost_empty_d;
  logic              rd_valid_q, rd_valid_d;

  logic [PtrWidth:0] wr_gray_sync;
  logic [PtrWidth:0] wr_bin_sync;
  logic              rd_acc;

  // -------------------------------------------------------------------------
  // Write-pointer synchroniser: plain shift register, first stage samples
  // the asynchronous Gray pointer. Only one Gray bit changes per write, so
  // a metastable first stage resolves to either the old or the new value.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < SyncStages; i++) begin
      sync_d[i] = '0;
    end
    sync_d[0] = i_wr_gray_ptr;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wr_gray_sync = sync_q[SyncStages-1];

  // Gray to binary: bit i is the XOR of Gray bits PtrWidth down to i.
  always_comb begin
    wr_bin_sync = '0;
    for (int i = 0; i <= PtrWidth; i++) begin
      wr_bin_sync[i] = ^(wr_gray_sync >> i);
    end
  end

  // -------------------------------------------------------------------------
  // Pointer and status next-state
  // -------------------------------------------------------------------------
  // Status is computed from the *next* pointer so that o_empty and o_level
  // already account for the read being accepted on this edge. A read is
  // never accepted while o_empty is high, so the pointer cannot overtake
  // the synchronised write pointer.
  assign rd_acc = i_rd_en & ~empty_q;

  always_comb begin
    bin_d          = bin_q + {{PtrWidth{1'b0}}, rd_acc};
    gray_d         = bin_d ^ (bin_d >> 1);
    empty_d        = (gray_d == wr_gray_sync);
    level_d        = wr_bin_sync - bin_d;
    almost_empty_d = (level_d <= THR);
    rd_valid_d     = rd_acc;
  end

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= '0;
      end
      bin_q          <= '0;
      gray_q         <= '0;
      level_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      rd_valid_q     <= 1'b0;
    end else begin
      for (int i = 0; i < SyncStages; i++) begin
        sync_q[i] <= sync_d[i];
      end
      bin_q          <= bin_d;
      gray_q         <= gray_d;
      level_q        <= level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Underflow flag
  // -------------------------------------------------------------------------
`ifdef RD_UNDERFLOW_FLAG_EN
  logic underflow_q, underflow_d;

  always_comb begin
    underflow_d = underflow_q | (i_rd_en & empty_q);
  end

  always_ff @(posedge clk_rd) begin
    if (rst_rd) begin
      underflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
    end
  end

  assign o_underflow = underflow_q;
`else
  assign o_underflow = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_bin_ptr      = bin_q;
  assign o_gray_ptr     = gray_q;
  assign o_addr         = bin_q[PtrWidth-1:0];
  assign o_rd_valid     = rd_valid_q;
  assign o_empty        = empty_q;
  assign o_almost_empty = almost_empty_q;
  assign o_level        = level_q;

endmodule

// File: doc/read_control_sync.md
Name: read_control_sync

Overview:
Next-generation read-side controller for the async FIFO. It owns the read binary/Gray pointers and the write-pointer synchroniser chain (parametrised depth). It produces registered empty, almost-empty and fill-level status plus a read-data-valid strobe for a registered RAM. It sits in the read clock domain between the FIFO RAM read port and the consumer.

Parameters:
PtrWidth, 2, address width; FIFO depth = 2**PtrWidth; pointers are PtrWidth+1 bits
SyncStages, 2, flops in the write-pointer synchroniser (legal >= 2)
AlmostEmptyThr, 1, o_almost_empty asserted when level <= this value (0 .. 2**PtrWidth)

Ports:
clk_rd  input  1  read-domain clock; all logic rising-edge
rst_rd  input  1  synchronous, active-high reset
i_rd_en  input  1  consumer read request
i_wr_gray_ptr  input  PtrWidth+1  write Gray pointer, asynchronous to clk_rd
o_bin_ptr  output  PtrWidth+1  read binary pointer
o_gray_ptr  output  PtrWidth+1  read Gray pointer, sent to the write domain
o_addr  output  PtrWidth  RAM read address = o_bin_ptr[PtrWidth-1:0]
o_rd_valid  output  1  RAM read data valid (one cycle after an accepted read)
o_empty  output  1  FIFO empty
o_almost_empty  output  1  level <= AlmostEmptyThr
o_level  output  PtrWidth+1  entries available, 0 .. 2**PtrWidth
o_underflow  output  1  sticky underflow error (see Optional Feature)

Behaviour:
- Single clock, rst_rd synchronous active-high. Reset values: o_bin_ptr=0, o_gray_ptr=0, o_rd_valid=0, o_empty=1, o_almost_empty=1, o_level=0, o_underflow=0, all synchroniser stages=0.
- Synchroniser: SyncStages-deep shift register on clk_rd; wr_gray_sync = last stage. wr_bin_sync = Gray-to-binary of wr_gray_sync (combinational; bit i = XOR of Gray bits PtrWidth..i).
- Accept: rd_acc = i_rd_en & ~o_empty. i_rd_en is ignored while o_empty=1, and the pointers hold.
- Next state: bin_d = o_bin_ptr + rd_acc (mod 2**(PtrWidth+1)); gray_d = bin_d ^ (bin_d >> 1).
- Status: empty_d = (gray_d == wr_gray_sync); level_d = wr_bin_sync - bin_d (mod 2**(PtrWidth+1)); almost_empty_d = (level_d <= AlmostEmptyThr).
- Registers: all of the above register every clk_rd edge. o_rd_valid <= rd_acc.
- Latency: a read request produces a pointer update on the next edge. A write-pointer change on i_wr_gray_ptr reaches o_empty/o_level after SyncStages+1 edges.
- Wrap: pointers wrap 2**(PtrWidth+1)-1 -> 0. The MSB distinguishes laps, and level arithmetic is modular.
- Simultaneous events: a write-pointer update in the same cycle as the last read uses the current synchronised value. Empty may stay asserted one extra cycle (pessimistic). It must never deassert early.
- Reset mid-operation: next edge forces reset values regardless of i_rd_en. No read is accepted in the reset cycle.

Optional Feature:
Macro RD_UNDERFLOW_FLAG_EN.
- Defined: o_underflow is set on any edge where i_rd_en=1 and o_empty=1. It is sticky and cleared only by rst_rd.
- Undefined: the port still exists and is tied to 0; no flop is inferred.
- Pointer behaviour is identical in both builds.

Test Plan:
(PtrWidth=2, SyncStages=2, AlmostEmptyThr=1)
- Reset with i_rd_en=1 held, i_wr_gray_ptr=0 -> ptrs 0, o_empty=1, o_almost_empty=1, o_level=0, o_rd_valid=0 for 5 cycles.
- i_wr_gray_ptr 000->001 at edge k -> o_empty=0 and o_level=1 after edge k+3, o_almost_empty=1. One read -> o_bin_ptr=1, o_gray_ptr=001, o_empty=1, o_level=0, o_rd_valid=1 for exactly one cycle after.
- i_wr_gray_ptr=110 (bin 4), o_bin_ptr=0, 4 back-to-back reads -> o_bin_ptr 1,2,3,4 / o_gray_ptr 001,011,010,110 / o_level 3,2,1,0. o_almost_empty rises with level 1; o_empty rises after the 4th read.
- Wrap: drive write ptr to bin 0 of the next lap (gray 000) after 8 total reads -> o_bin_ptr wraps 111->000, o_gray_ptr 100->000, o_empty=1.
- Underflow: i_rd_en=1 while empty -> pointers unchanged, o_rd_valid=0. With RD_UNDERFLOW_FLAG_EN, o_underflow=1 and it stays 1 until rst_rd; without the macro it stays 0.
- Mid-run reset: o_bin_ptr=3, i_rd_en=1, rst_rd pulsed one cycle -> next edge all reset values and sync chain cleared. o_empty stays 1 until SyncStages+1 edges after the write pointer is re-presented.
